// File: rtl/pdetect_stream_skid.sv
// In-line maskable pattern detector on a valid/ready stream. The match flag rides as
// sideband on the completing beat; a 2-entry skid buffer registers both handshake directions.
module pdetect_stream_skid #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int OVERLAP = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [PAT_LEN*DATA_W-1:0] i_pattern,
  input  logic [PAT_LEN*DATA_W-1:0] i_mask,
  input  logic                      i_count_clr,
  input  logic [DATA_W-1:0]         i_m_data,
  input  logic                      i_m_valid,
  output logic                      o_m_ready,
  output logic [DATA_W-1:0]         o_s_data,
  output logic                      o_s_valid,
  output logic                      o_s_match,
  input  logic                      i_s_ready,
  output logic                      o_detected,
  output logic [15:0]               o_match_count
);
  localparam int HW = (PAT_LEN-1)*DATA_W;
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN-1);

  logic [HW-1:0]             hist_q, hist_d;
  logic [FW-1:0]             fill_q, fill_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_match_q, out_match_d;
  logic                      skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]         skid_data_q, skid_data_d;
  logic                      skid_match_q, skid_match_d;
  logic                      m_ready_q, m_ready_d;
  logic                      det_q, det_d;
  logic [15:0]               cnt_q, cnt_d;

  logic [PAT_LEN*DATA_W-1:0] window;
  logic                      accept, xfer, match;

  // Oldest history beat sits in the MS slice, matching the pattern layout.
  always_comb begin
    window = {hist_q, i_m_data};
    accept = i_m_valid && m_ready_q;
    xfer   = out_valid_q && i_s_ready;
    match  = accept && i_enable && (fill_q == FILL_MAX) &&
             (((window ^ i_pattern) & i_mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (accept) begin
      hist_d = window[HW-1:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
      if (match && (OVERLAP == 0)) fill_d = '0;
    end
    if (!i_enable) fill_d = '0;
  end

  // A beat is only accepted while the skid is empty, so accept and skid-drain never collide.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_match_d  = out_match_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_match_d = skid_match_q;
    if (xfer) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_match_d  = skid_match_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
      end
    end
    if (accept) begin
      if (!out_valid_q || xfer) begin
        out_valid_d  = 1'b1;
        out_data_d   = i_m_data;
        out_match_d  = match;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = i_m_data;
        skid_match_d = match;
      end
    end
    m_ready_d = !skid_valid_d;
  end

  always_comb begin
    det_d = match;
    cnt_d = cnt_q;
    if (i_count_clr)                   cnt_d = '0;
    else if (match && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q       <= '0;
      fill_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_match_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_match_q <= 1'b0;
      m_ready_q    <= 1'b0;
      det_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_match_q  <= out_match_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_match_q <= skid_match_d;
      m_ready_q    <= m_ready_d;
      det_q        <= det_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_m_ready     = m_ready_q;
  assign o_s_data      = out_data_q;
  assign o_s_valid     = out_valid_q;
  assign o_s_match     = out_match_q;
  assign o_detected    = det_q;
  assign o_match_count = cnt_q;

endmodule

// File: tb/tb_pdetect_stream_skid.sv
// Bench for pdetect_stream_skid: two instances (overlap on/off) share one stimulus stream;
// each has a queue-based reference model and a negedge monitor.
module tb_pdetect_stream_skid;
  localparam int DATA_W  = 8;
  localparam int PAT_LEN = 4;
  localparam int PW      = DATA_W*PAT_LEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, enable, count_clr, m_valid, s_ready;
  logic [PW-1:0]     pattern, mask;
  logic [DATA_W-1:0] m_data;
  logic              rand_rdy, lat_chk;
  int                n_tests, n_fail;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat idx of the pattern (0 = oldest) matches b under the mask.
  function automatic bit beat_ok(input int idx, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] p, mk;
    p  = pattern[(PAT_LEN-1-idx)*DATA_W +: DATA_W];
    mk = mask[(PAT_LEN-1-idx)*DATA_W +: DATA_W];
    return ((b ^ p) & mk) == '0;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int OVL = (k == 0) ? 1 : 0;
    logic              m_ready, s_valid, s_match, detected;
    logic [DATA_W-1:0] s_data;
    logic [15:0]       count;
    logic [DATA_W:0]   expq[$];
    logic [DATA_W-1:0] win[$];
    logic [DATA_W:0]   e;
    logic [DATA_W-1:0] prev_data;
    logic              det_exp = 1'b0, prev_stall = 1'b0, prev_match, last_acc = 1'b0;
    logic              hit, acc, xfer;
    int                cnt_exp = 0, n_smatch = 0, n_det = 0;

    pdetect_stream_skid #(.DATA_W(DATA_W), .PAT_LEN(PAT_LEN), .OVERLAP(OVL)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pattern(pattern), .i_mask(mask),
      .i_count_clr(count_clr), .i_m_data(m_data), .i_m_valid(m_valid), .o_m_ready(m_ready),
      .o_s_data(s_data), .o_s_valid(s_valid), .o_s_match(s_match), .i_s_ready(s_ready),
      .o_detected(detected), .o_match_count(count)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        check($sformatf("rst_m_ready[%0d]", k), m_ready, 0);
        check($sformatf("rst_s_valid[%0d]", k), s_valid, 0);
        check($sformatf("rst_s_data[%0d]", k), s_data, 0);
        check($sformatf("rst_s_match[%0d]", k), s_match, 0);
        check($sformatf("rst_detected[%0d]", k), detected, 0);
        check($sformatf("rst_count[%0d]", k), count, 0);
        expq.delete();
        win.delete();
        det_exp = 1'b0; cnt_exp = 0; prev_stall = 1'b0; last_acc = 1'b0;
      end else begin
        check($sformatf("detected[%0d]", k), detected, det_exp);
        check($sformatf("match_count[%0d]", k), count, cnt_exp);
        if (detected) n_det++;
        if (prev_stall) begin
          check($sformatf("stall_valid[%0d]", k), s_valid, 1);
          check($sformatf("stall_data[%0d]", k), s_data, prev_data);
          check($sformatf("stall_match[%0d]", k), s_match, prev_match);
        end
        if (lat_chk) check($sformatf("latency[%0d]", k), s_valid, last_acc);
        acc  = m_valid && m_ready;
        xfer = s_valid && s_ready;
        if (xfer) begin
          if (s_match) n_smatch++;
          if (expq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat[%0d]: got %0h expected none", k, s_data);
          end else begin
            e = expq.pop_front();
            check($sformatf("out_data[%0d]", k), s_data, e[DATA_W-1:0]);
            check($sformatf("out_match[%0d]", k), s_match, e[DATA_W]);
          end
        end
        hit = 1'b0;
        if (!enable) win.delete();
        else if (acc) begin
          win.push_back(m_data);
          if (win.size() >= PAT_LEN) begin
            hit = 1'b1;
            for (int i = 0; i < PAT_LEN; i++)
              if (!beat_ok(i, win[win.size()-PAT_LEN+i])) hit = 1'b0;
          end
          while (win.size() > PAT_LEN) void'(win.pop_front());
          if (hit && OVL == 0) win.delete();
        end
        if (acc) expq.push_back({hit, m_data});
        det_exp = hit;
        if (count_clr) cnt_exp = 0;
        else if (hit && cnt_exp != 65535) cnt_exp++;
        prev_stall = s_valid && !s_ready;
        prev_data  = s_data;
        prev_match = s_match;
        last_acc   = acc;
      end
    end
  end

  initial begin
    s_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      s_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    bit acc;
    int guard;
    m_valid = 1'b1; m_data = b; acc = 0; guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = g_inst[0].m_ready;
      check("ready_agree", g_inst[1].m_ready, g_inst[0].m_ready);
      tick();
      guard++;
      if (!acc && guard > 1000) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
        break;
      end
    end
    m_valid = 1'b0;
  endtask

  task automatic send_word(input logic [PW-1:0] w);
    for (int i = PAT_LEN-1; i >= 0; i--) send(w[i*DATA_W +: DATA_W]);
  endtask

  task automatic flush();
    m_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic clear_count();
    count_clr = 1'b1; tick(); count_clr = 1'b0;
  endtask

  task automatic set_pattern(input logic [PW-1:0] p, input logic [PW-1:0] m);
    enable = 1'b0; pattern = p; mask = m; tick(); enable = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1; tick();
  endtask

  task automatic check_counts(input string name, input int c0, input int c1);
    check({name, "_ovl1"}, g_inst[0].count, c0);
    check({name, "_ovl0"}, g_inst[1].count, c1);
  endtask

  initial begin
    int sent, guard;
    logic [DATA_W-1:0] b;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; enable = 1'b0; count_clr = 1'b0; m_valid = 1'b0; m_data = '0;
    rand_rdy = 1'b0; lat_chk = 1'b0;
    pattern = 32'h0A0B0C0D; mask = '1;
    repeat (3) tick();
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);
    check("ready_before_first_clk", g_inst[0].m_ready, 0);
    tick();
    check("ready_after_release", g_inst[0].m_ready, 1);
    lat_chk = 1'b1;

    send(8'h00); send_word(32'h0A0B0C0D); send(8'h11); flush();
    check_counts("basic_count", 1, 1);

    clear_count(); set_pattern(32'hAAAAAAAA, '1);
    repeat (6) send(8'hAA); flush();
    check_counts("overlap6_count", 3, 1);
    repeat (2) send(8'hAA); flush();
    check_counts("overlap8_count", 5, 2);

    do_reset(); set_pattern(32'h00000000, '1);
    repeat (3) send(8'h00); flush();
    check_counts("zero_guard_3", 0, 0);
    send(8'h00); flush();
    check_counts("zero_guard_4", 1, 1);

    clear_count(); set_pattern(32'h0A0B0C0D, 32'hFF00FFFF);
    send_word(32'h0A770C0D); flush();
    check_counts("mask_hit", 1, 1);
    send_word(32'h0A770C0E); flush();
    check_counts("mask_miss", 1, 1);

    set_pattern(32'h0A0B0C0D, '1);
    send(8'h0A); send(8'h0B); send(8'h0C);
    do_reset(); send(8'h0D); flush();
    check_counts("reset_mid", 0, 0);
    send(8'h0A); send(8'h0B); send(8'h0C);
    enable = 1'b0; tick(); enable = 1'b1;
    send(8'h0D); flush();
    check_counts("enable_drop", 0, 0);
    send_word(32'h0A0B0C0D); flush();
    check_counts("pre_clr", 1, 1);
    send(8'h0A); send(8'h0B); send(8'h0C);
    count_clr = 1'b1; send(8'h0D); count_clr = 1'b0; flush();
    check_counts("clr_priority", 0, 0);

    force g_inst[0].dut.cnt_q = 16'hFFFF;
    force g_inst[1].dut.cnt_q = 16'hFFFF;
    g_inst[0].cnt_exp = 65535; g_inst[1].cnt_exp = 65535;
    tick();
    release g_inst[0].dut.cnt_q;
    release g_inst[1].dut.cnt_q;
    send_word(32'h0A0B0C0D); flush();
    check_counts("saturate", 16'hFFFF, 16'hFFFF);

    clear_count(); tick();
    lat_chk = 1'b0; rand_rdy = 1'b1;
    for (int k = 0; k < 2; k++) ;
    g_inst[0].n_smatch = 0; g_inst[0].n_det = 0;
    g_inst[1].n_smatch = 0; g_inst[1].n_det = 0;
    sent = 0;
    while (sent < 10000) begin
      while ($urandom_range(0, 1) == 1) tick();
      if ($urandom_range(0, 499) == 0) begin
        enable = 1'b0; tick(); enable = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        send_word(32'h0A0B0C0D); sent += 4;
      end else begin
        case ($urandom_range(0, 4))
          0: b = 8'h0A;
          1: b = 8'h0B;
          2: b = 8'h0C;
          3: b = 8'h0D;
          default: b = 8'($urandom);
        endcase
        send(b); sent++;
      end
    end
    m_valid = 1'b0; rand_rdy = 1'b0;
    guard = 0;
    while ((g_inst[0].expq.size() != 0 || g_inst[1].expq.size() != 0) && guard < 100) begin
      tick(); guard++;
    end
    repeat (3) tick();
    check("drain_ovl1", g_inst[0].expq.size(), 0);
    check("drain_ovl0", g_inst[1].expq.size(), 0);
    check("smatch_vs_det_ovl1", g_inst[0].n_smatch, g_inst[0].n_det);
    check("smatch_vs_det_ovl0", g_inst[1].n_smatch, g_inst[1].n_det);
    check("det_vs_count_ovl1", g_inst[0].count, g_inst[0].n_det);
    check("det_vs_count_ovl0", g_inst[1].count, g_inst[1].n_det);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
